conv_seq_ctrl: RTL and testbench

- Top-level sequencer for the two-layer convolution datapath (conv_dp).
- Issues the start pulses and the layer-2 memory write enable in the fixed order: L1 memory load, L1 PE compute, L2 memory write-back, L2 memory load, L2 PE compute.
- Latches the L1 window configuration (x, y, z) for the whole run.
- Guards every wait phase with a watchdog and reports done or error to the host.

---
 rtl/conv_ctrl_pkg.sv | 33 +++
 rtl/ctrl_watchdog.sv | 34 +++
 rtl/conv_seq_ctrl.sv | 163 ++++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_ctrl_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// conv_ctrl_pkg : shared state encoding and defaults for conv_seq_ctrl
// Rev 1.0
// ------------------------------------------------------------------
package conv_ctrl_pkg;

  localparam int STATE_W       = 4;
  localparam int DEF_TIMEOUT   = 4096;
  localparam int DEF_WR_CYCLES = 1;

  // Low 3 bits of the four wait states are distinct; they double as err_phase.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 4'd0,
    ST_L1M   = 4'd1,
    ST_L1M_W = 4'd2,
    ST_L1P   = 4'd3,
    ST_L1P_W = 4'd4,
    ST_L2WR  = 4'd5,
    ST_L2M   = 4'd6,
    ST_L2M_W = 4'd7,
    ST_L2P   = 4'd8,
    ST_L2P_W = 4'd9,
    ST_DONE  = 4'd10,
    ST_ERR   = 4'd11
  } state_e;

  function automatic logic is_wait(input state_e s);
    return (s == ST_L1M_W) || (s == ST_L1P_W) || (s == ST_L2M_W) || (s == ST_L2P_W);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_watchdog.sv
`default_nettype none
// ------------------------------------------------------------------
// ctrl_watchdog : cycle counter with sync clear, enable and terminal flag
// Rev 1.0
// ------------------------------------------------------------------
module ctrl_watchdog #(
  parameter int CNT_W  = 16,
  parameter int TC_VAL = 4095
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;
  assign tc  = (r_cnt == CNT_W'(TC_VAL));

endmodule
`default_nettype wire

// File: rtl/conv_seq_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// conv_seq_ctrl : issue/wait sequencer for the two-layer conv datapath
// Rev 1.0
// ------------------------------------------------------------------
module conv_seq_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int WR_CYCLES = DEF_WR_CYCLES,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       cfg_x,
  input  logic [7:0]       cfg_y,
  input  logic [7:0]       cfg_z,
  input  logic             done_mem_l1,
  input  logic             done_pe_l1,
  input  logic             done_mem_l2,
  input  logic             done_pe_l2,
  output logic             start_mem_l1,
  output logic             start_pe_l1,
  output logic             start_mem_l2,
  output logic             start_pe_l2,
  output logic             wrmem_en_l2,
  output logic [7:0]       x,
  output logic [7:0]       y,
  output logic [7:0]       z,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [2:0]       err_phase,
  output logic [CNT_W-1:0] run_cycles
);

  state_e           r_state;
  logic [CNT_W-1:0] w_wd_cnt;
  logic             w_wd_tc;
  logic             w_wd_en;
  logic             w_wd_clr;
  logic             w_wait_done;
  logic             w_wr_last;

  always_comb begin
    w_wait_done = 1'b0;
    case (r_state)
      ST_L1M_W: w_wait_done = done_mem_l1;
      ST_L1P_W: w_wait_done = done_pe_l1;
      ST_L2M_W: w_wait_done = done_mem_l2;
      ST_L2P_W: w_wait_done = done_pe_l2;
      default:  w_wait_done = 1'b0;
    endcase
  end

  // Counter runs in wait states and L2WR; L1P_W hands over straight to L2WR, so clear on done.
  assign w_wd_en   = is_wait(r_state) || (r_state == ST_L2WR);
  assign w_wd_clr  = !w_wd_en || w_wait_done;
  assign w_wr_last = (w_wd_cnt == CNT_W'(WR_CYCLES - 1));

  ctrl_watchdog #(
    .CNT_W  (CNT_W),
    .TC_VAL (TIMEOUT - 1)
  ) u_wdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_wd_clr),
    .en    (w_wd_en),
    .cnt   (w_wd_cnt),
    .tc    (w_wd_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      start_mem_l1 <= 1'b0;
      start_pe_l1  <= 1'b0;
      start_mem_l2 <= 1'b0;
      start_pe_l2  <= 1'b0;
      wrmem_en_l2  <= 1'b0;
      x            <= '0;
      y            <= '0;
      z            <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_phase    <= '0;
      run_cycles   <= '0;
    end else begin
      start_mem_l1 <= 1'b0;
      start_pe_l1  <= 1'b0;
      start_mem_l2 <= 1'b0;
      start_pe_l2  <= 1'b0;

      if (busy && (run_cycles != '1)) begin
        run_cycles <= run_cycles + 1'b1;
      end

      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            x            <= cfg_x;
            y            <= cfg_y;
            z            <= cfg_z;
            done         <= 1'b0;
            err          <= 1'b0;
            run_cycles   <= '0;
            busy         <= 1'b1;
            start_mem_l1 <= 1'b1;
            r_state      <= ST_L1M;
          end
        end
        ST_L1M: r_state <= ST_L1M_W;
        ST_L1P: r_state <= ST_L1P_W;
        ST_L2M: r_state <= ST_L2M_W;
        ST_L2P: r_state <= ST_L2P_W;
        ST_L1M_W, ST_L1P_W, ST_L2M_W, ST_L2P_W: begin
          if (w_wait_done) begin
            case (r_state)
              ST_L1M_W: begin
                start_pe_l1 <= 1'b1;
                r_state     <= ST_L1P;
              end
              ST_L1P_W: begin
                wrmem_en_l2 <= 1'b1;
                r_state     <= ST_L2WR;
              end
              ST_L2M_W: begin
                start_pe_l2 <= 1'b1;
                r_state     <= ST_L2P;
              end
              default: begin
                busy    <= 1'b0;
                done    <= 1'b1;
                r_state <= ST_DONE;
              end
            endcase
          end else if (w_wd_tc) begin
            busy      <= 1'b0;
            err       <= 1'b1;
            err_phase <= r_state[2:0];
            r_state   <= ST_ERR;
          end
        end
        ST_L2WR: begin
          if (w_wr_last) begin
            wrmem_en_l2  <= 1'b0;
            start_mem_l2 <= 1'b1;
            r_state      <= ST_L2M;
          end
        end
        default: begin
          busy        <= 1'b0;
          wrmem_en_l2 <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_seq_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_conv_seq_ctrl : randomized bench for conv_seq_ctrl with phase-level model
// Rev 1.0
// ------------------------------------------------------------------
module tb_conv_seq_ctrl;
  import conv_ctrl_pkg::*;

  localparam int TB_TIMEOUT = 32;
  localparam int TB_WR      = 1;
  localparam int CW         = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    cfg_x = '0, cfg_y = '0, cfg_z = '0;
  logic [3:0]    dn = '0;
  logic          start_mem_l1, start_pe_l1, start_mem_l2, start_pe_l2, wrmem_en_l2;
  logic [7:0]    x, y, z;
  logic          busy, done, err;
  logic [2:0]    err_phase;
  logic [CW-1:0] run_cycles;
  logic [50:0]   all_out;

  conv_seq_ctrl #(.WR_CYCLES(TB_WR), .TIMEOUT(TB_TIMEOUT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_z(cfg_z),
    .done_mem_l1(dn[0]), .done_pe_l1(dn[1]), .done_mem_l2(dn[2]), .done_pe_l2(dn[3]),
    .start_mem_l1(start_mem_l1), .start_pe_l1(start_pe_l1),
    .start_mem_l2(start_mem_l2), .start_pe_l2(start_pe_l2),
    .wrmem_en_l2(wrmem_en_l2), .x(x), .y(y), .z(z),
    .busy(busy), .done(done), .err(err), .err_phase(err_phase), .run_cycles(run_cycles)
  );

  assign all_out = {start_mem_l1, start_pe_l1, start_mem_l2, start_pe_l2, wrmem_en_l2,
                    busy, done, err, err_phase, x, y, z, run_cycles};

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Datapath stand-in: a start pulse drops its done, which rises dly cycles later (0 = never).
  int   dly[4];
  int   cnt_dn[4];
  logic hold_l1 = 1'b0;

  always @(negedge clk) begin
    logic [3:0] pulse;
    pulse = {start_pe_l2, start_mem_l2, start_pe_l1, start_mem_l1};
    for (int i = 0; i < 4; i++) begin
      if (pulse[i]) begin
        cnt_dn[i] = dly[i];
        dn[i] = 1'b0;
      end else if (cnt_dn[i] > 0) begin
        cnt_dn[i]--;
        if (cnt_dn[i] == 0) dn[i] = 1'b1;
      end
    end
    if (hold_l1) dn[0] = 1'b1;
  end

  // Event log: 0 mem_l1, 1 pe_l1, 2 wrmem cycle, 3 mem_l2, 4 pe_l2, 5 done rise, 6 err rise.
  typedef struct { int code; int t; } ev_t;
  ev_t  evq[$];
  ev_t  exp_q[$];
  int   ncyc = 0;
  logic prev_done = 1'b0, prev_err = 1'b0;

  function automatic ev_t mk(input int c, input int t);
    ev_t e;
    e.code = c;
    e.t    = t;
    return e;
  endfunction

  always @(negedge clk) begin
    ncyc++;
    if (start_mem_l1) evq.push_back(mk(0, ncyc));
    if (start_pe_l1)  evq.push_back(mk(1, ncyc));
    if (wrmem_en_l2)  evq.push_back(mk(2, ncyc));
    if (start_mem_l2) evq.push_back(mk(3, ncyc));
    if (start_pe_l2)  evq.push_back(mk(4, ncyc));
    if (done && !prev_done) evq.push_back(mk(5, ncyc));
    if (err && !prev_err)   evq.push_back(mk(6, ncyc));
    prev_done = done;
    prev_err  = err;
  end

  int         exp_cycles;
  logic       exp_err;
  logic [2:0] exp_phase;

  // Each issue phase costs one pulse cycle plus its done latency; a latency beyond TIMEOUT means ERR.
  task automatic model(input int d[4]);
    int         t;
    int         code_of[4] = '{0, 1, 3, 4};
    state_e     wst[4] = '{ST_L1M_W, ST_L1P_W, ST_L2M_W, ST_L2P_W};
    logic [3:0] wcode;
    exp_q.delete();
    t = 0;
    exp_err = 1'b0;
    exp_phase = '0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(code_of[i], t));
      if (d[i] == 0 || d[i] > TB_TIMEOUT) begin
        t += 1 + TB_TIMEOUT;
        exp_err = 1'b1;
        wcode = wst[i];
        exp_phase = wcode[2:0];
        exp_q.push_back(mk(6, t));
        exp_cycles = t;
        return;
      end
      t += 1 + d[i];
      if (i == 1) begin
        for (int k = 0; k < TB_WR; k++) exp_q.push_back(mk(2, t + k));
        t += TB_WR;
      end
    end
    exp_q.push_back(mk(5, t));
    exp_cycles = t;
  endtask

  task automatic run(input string nm, input logic [7:0] cx, input logic [7:0] cy, input logic [7:0] cz,
                     input int d0, input int d1, input int d2, input int d3, input logic poke);
    int d[4];
    int guard;
    int t0;
    d = '{d0, d1, d2, d3};
    for (int i = 0; i < 4; i++) dly[i] = d[i];
    model(d);
    evq.delete();
    @(negedge clk);
    start = 1'b1; cfg_x = cx; cfg_y = cy; cfg_z = cz;
    @(negedge clk);
    start = 1'b0; cfg_x = ~cx; cfg_y = ~cy; cfg_z = ~cz;
    check({nm, ".accept"}, {busy, done, err, x, y, z}, {1'b1, 1'b0, 1'b0, cx, cy, cz});
    if (poke) begin
      guard = 0;
      while (!start_pe_l1 && guard < 100) begin @(negedge clk); guard++; end
      @(negedge clk); @(negedge clk);
      start = 1'b1; cfg_x = 8'd1; cfg_y = 8'd2; cfg_z = 8'd3;
      @(negedge clk);
      start = 1'b0;
    end
    guard = 0;
    while (!(done || err) && guard < 400) begin @(negedge clk); guard++; end
    #1;
    check({nm, ".finished"}, guard < 400, 1'b1);
    check({nm, ".n_events"}, evq.size(), exp_q.size());
    t0 = (evq.size() > 0) ? evq[0].t : 0;
    for (int i = 0; i < exp_q.size() && i < evq.size(); i++) begin
      check($sformatf("%s.ev%0d", nm, i), {evq[i].code, evq[i].t - t0}, {exp_q[i].code, exp_q[i].t});
    end
    check({nm, ".status"}, {busy, done, err}, {1'b0, ~exp_err, exp_err});
    check({nm, ".run_cycles"}, run_cycles, exp_cycles[CW-1:0]);
    check({nm, ".xyz"}, {x, y, z}, {cx, cy, cz});
    if (exp_err) check({nm, ".err_phase"}, err_phase, exp_phase);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int guard;
    int dd[4];
    for (int i = 0; i < 4; i++) begin dly[i] = 5; cnt_dn[i] = 0; end
    repeat (3) @(negedge clk);
    check("reset.asserted", all_out, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset.released", all_out, '0);

    run("nominal", 8'd16, 8'd0, 8'd16, 5, 5, 5, 5, 1'b0);
    check("nominal.hand_count", run_cycles, 16'd25);
    run("restart_done", 8'd8, 8'd8, 8'd8, 3, 4, 2, 6, 1'b0);
    run("timeout", 8'd4, 8'd5, 8'd6, 5, 0, 5, 5, 1'b0);
    run("restart_err", 8'd8, 8'd8, 8'd8, 5, 5, 5, 5, 1'b0);
    run("done_at_limit", 8'd9, 8'd9, 8'd9, TB_TIMEOUT, 2, 2, 2, 1'b0);
    run("past_limit", 8'd7, 8'd7, 8'd7, 2, 2, TB_TIMEOUT + 1, 2, 1'b0);

    hold_l1 = 1'b1;
    @(negedge clk); @(negedge clk);
    run("early_done", 8'd3, 8'd3, 8'd3, 1, 5, 5, 5, 1'b0);
    hold_l1 = 1'b0;

    run("busy_start", 8'd16, 8'd0, 8'd16, 5, 6, 5, 5, 1'b1);

    for (int i = 0; i < 4; i++) dly[i] = 5;
    @(negedge clk);
    start = 1'b1; cfg_x = 8'd11; cfg_y = 8'd12; cfg_z = 8'd13;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!wrmem_en_l2 && guard < 100) begin @(negedge clk); guard++; end
    check("midrst.wr_seen", wrmem_en_l2, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.async_clear", all_out, '0);
    @(negedge clk); @(negedge clk);
    check("midrst.held", all_out, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst.idle", all_out, '0);
    run("post_reset", 8'd21, 8'd22, 8'd23, 4, 4, 4, 4, 1'b0);

    for (int it = 0; it < 10; it++) begin
      int r;
      for (int i = 0; i < 4; i++) dd[i] = $urandom_range(1, 10);
      r = $urandom_range(0, 5);
      if (r == 0) dd[$urandom_range(0, 3)] = 0;
      if (r == 1) dd[$urandom_range(0, 3)] = TB_TIMEOUT;
      if (r == 2) dd[$urandom_range(0, 3)] = TB_TIMEOUT + 1;
      run($sformatf("rand%0d", it), 8'($urandom), 8'($urandom), 8'($urandom),
          dd[0], dd[1], dd[2], dd[3], 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
